// File: rtl/aplic_msi_notifier.sv
// aplic_msi_notifier: round-robin scanner that turns pending-and-enabled
// APLIC sources owned by MSI-mode domains into MSI writes (address = domain
// base + hart << 12, data = EIID) and requests the pending bit be cleared
// once the bus master has accepted the write.
module aplic_msi_notifier #(
  parameter int NrSources = 256,
  parameter int NrHarts   = 5,
  parameter int NrDomains = 2,
  parameter int AddrW     = 64,
  parameter int EiidW     = 11,
  localparam int SrcW     = (NrSources > 1) ? $clog2(NrSources) : 1,
  localparam int HartW    = (NrHarts   > 1) ? $clog2(NrHarts)   : 1,
  localparam int DomW     = (NrDomains > 1) ? $clog2(NrDomains) : 1
) (
  input  logic                         i_clk,
  input  logic                         ni_rst,
  input  logic [NrSources-1:0]         i_pending,
  input  logic [NrSources-1:0]         i_enabled,
  input  logic [NrSources*DomW-1:0]    i_src_domain,
  input  logic [NrSources*HartW-1:0]   i_src_hart,
  input  logic [NrSources*EiidW-1:0]   i_src_eiid,
  input  logic [NrDomains-1:0]         i_domain_ie,
  input  logic [NrDomains-1:0]         i_domain_mode,
  input  logic [NrDomains*AddrW-1:0]   i_msi_base,
  output logic                         o_msi_valid,
  input  logic                         i_msi_ready,
  output logic [AddrW-1:0]             o_msi_addr,
  output logic [31:0]                  o_msi_data,
  output logic                         o_clr_valid,
  output logic [SrcW-1:0]              o_clr_idx
);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    ISSUE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [SrcW-1:0] LastSrc  = SrcW'(NrSources - 1);
  localparam logic [SrcW-1:0] FirstSrc = SrcW'(1);

  state_t          state, state_next;
  logic [SrcW-1:0] ptr;
  logic [SrcW-1:0] ptr_inc;

  // Per-source configuration fields selected by the scan pointer.
  logic [DomW-1:0]  cur_dom;
  logic [HartW-1:0] cur_hart;
  logic [EiidW-1:0] cur_eiid;
  logic [AddrW-1:0] cur_base;
  logic             dom_ok;
  logic             hart_ok;
  logic             qualifies;

  assign cur_dom  = i_src_domain[int'(ptr)*DomW  +: DomW];
  assign cur_hart = i_src_hart  [int'(ptr)*HartW +: HartW];
  assign cur_eiid = i_src_eiid  [int'(ptr)*EiidW +: EiidW];
  assign cur_base = i_msi_base  [int'(cur_dom)*AddrW +: AddrW];

  // Range checks are done one bit wider so non-power-of-two counts work.
  assign dom_ok  = {1'b0, cur_dom}  < (DomW+1)'(NrDomains);
  assign hart_ok = {1'b0, cur_hart} < (HartW+1)'(NrHarts);

  // Source 0 is reserved; the pointer never rests on it, but the guard keeps
  // the qualifier self-contained.
  assign qualifies = (ptr != '0) && i_pending[ptr] && i_enabled[ptr] &&
                     dom_ok && i_domain_ie[cur_dom] && i_domain_mode[cur_dom] &&
                     hart_ok && (cur_eiid != '0);

  // Pointer increment with wrap from the last source back to source 1.
  assign ptr_inc = (ptr == LastSrc) ? FirstSrc : ptr + FirstSrc;

  // State register; async reset returns to SCAN so a pending request is
  // withdrawn immediately and rediscovered after reset.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state <= SCAN;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    state_next  = state;
    o_msi_valid = 1'b0;
    o_clr_valid = 1'b0;
    unique case (state)
      SCAN: begin
        if (qualifies) state_next = ISSUE;
      end
      ISSUE: begin
        o_msi_valid = 1'b1;
        if (i_msi_ready) state_next = CLEAR;
      end
      CLEAR: begin
        o_clr_valid = 1'b1;
        state_next  = SCAN;
      end
      default: state_next = SCAN;
    endcase
  end

  // Scan pointer and latched payload. The payload is captured once, in the
  // cycle the source is found, and held through ISSUE and CLEAR.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      // NOTE: these are a handful of output registers, not a memory, so
      // they are reset to give defined outputs straight out of reset.
      ptr        <= FirstSrc;
      o_msi_addr <= '0;
      o_msi_data <= '0;
      o_clr_idx  <= '0;
    end else begin
      unique case (state)
        SCAN: begin
          if (qualifies) begin
            o_msi_addr <= cur_base + (AddrW'(cur_hart) << 12);
            o_msi_data <= 32'(cur_eiid);
            o_clr_idx  <= ptr;
          end else begin
            ptr <= ptr_inc;
          end
        end
        ISSUE: begin
          // Hold pointer and payload until accepted.
        end
        CLEAR: begin
          // Resume one past the serviced source for round-robin fairness.
          ptr <= ptr_inc;
        end
        default: ptr <= FirstSrc;
      endcase
    end
  end

endmodule

// File: tb/tb_aplic_msi_notifier.sv
// Directed self-checking bench for aplic_msi_notifier. Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on rising edges.
module tb_aplic_msi_notifier;

  localparam int NrSources = 256;
  localparam int NrHarts   = 5;
  localparam int NrDomains = 2;
  localparam int AddrW     = 64;
  localparam int EiidW     = 11;
  localparam int SrcW      = 8;
  localparam int HartW     = 3;
  localparam int DomW      = 1;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NrSources-1:0]       pending;
  logic [NrSources-1:0]       enabled;
  logic [NrSources*DomW-1:0]  src_domain;
  logic [NrSources*HartW-1:0] src_hart;
  logic [NrSources*EiidW-1:0] src_eiid;
  logic [NrDomains-1:0]       domain_ie;
  logic [NrDomains-1:0]       domain_mode;
  logic [NrDomains*AddrW-1:0] msi_base;
  logic                       msi_valid;
  logic                       msi_ready;
  logic [AddrW-1:0]           msi_addr;
  logic [31:0]                msi_data;
  logic                       clr_valid;
  logic [SrcW-1:0]            clr_idx;

  int vectors = 0;
  int errors  = 0;
  int cycles;
  int cnt;

  aplic_msi_notifier #(
    .NrSources(NrSources), .NrHarts(NrHarts), .NrDomains(NrDomains),
    .AddrW(AddrW), .EiidW(EiidW)
  ) dut (
    .i_clk        (clk),
    .ni_rst       (rst_n),
    .i_pending    (pending),
    .i_enabled    (enabled),
    .i_src_domain (src_domain),
    .i_src_hart   (src_hart),
    .i_src_eiid   (src_eiid),
    .i_domain_ie  (domain_ie),
    .i_domain_mode(domain_mode),
    .i_msi_base   (msi_base),
    .o_msi_valid  (msi_valid),
    .i_msi_ready  (msi_ready),
    .o_msi_addr   (msi_addr),
    .o_msi_data   (msi_data),
    .o_clr_valid  (clr_valid),
    .o_clr_idx    (clr_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    pending     = '0;
    enabled     = '0;
    src_domain  = '0;
    src_hart    = '0;
    src_eiid    = '0;
    domain_ie   = '0;
    domain_mode = '0;
    msi_base    = '0;
    msi_ready   = 1'b0;
  endtask

  task automatic set_src(input int s, input int dom, input int hart, input int eiid);
    src_domain[s*DomW +: DomW]    = DomW'(dom);
    src_hart[s*HartW +: HartW]    = HartW'(hart);
    src_eiid[s*EiidW +: EiidW]    = EiidW'(eiid);
    pending[s] = 1'b1;
    enabled[s] = 1'b1;
  endtask

  task automatic set_domain(input int d, input bit ie, input bit mode, input logic [63:0] base);
    domain_ie[d]               = ie;
    domain_mode[d]             = mode;
    msi_base[d*AddrW +: AddrW] = base;
  endtask

  // Reset is applied and released on falling edges.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
  endtask

  // Bounded wait for o_msi_valid; caller checks both valid and cycle count.
  task automatic wait_msi(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!msi_valid && n < budget);
  endtask

  task automatic count_valid(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (msi_valid) hits++;
    end
  endtask

  initial begin
    clear_all();
    rst_n = 1'b0;

    // ---- 1: reset values, single MSI for source 5 ----------------------
    set_domain(0, 1'b1, 1'b1, 64'h2800_0000);
    set_src(5, 0, 3, 'h2A);
    msi_ready = 1'b1;
    do_reset();
    check("rst_valid", 64'(msi_valid), 64'd0);
    check("rst_clr",   64'(clr_valid), 64'd0);
    check("rst_addr",  msi_addr,       64'd0);
    check("rst_data",  64'(msi_data),  64'd0);
    check("rst_idx",   64'(clr_idx),   64'd0);
    release_reset();
    wait_msi(600, cycles);
    check("t1_valid",   64'(msi_valid), 64'd1);
    check("t1_latency", 64'(cycles),    64'd5);
    check("t1_addr",    msi_addr,       64'h2800_3000);
    check("t1_data",    64'(msi_data),  64'h2A);
    @(negedge clk);
    check("t1_clr",     64'(clr_valid), 64'd1);
    check("t1_clr_idx", 64'(clr_idx),   64'd5);
    check("t1_vdrop",   64'(msi_valid), 64'd0);
    pending[5] = 1'b0;
    @(negedge clk);
    check("t1_clr_1cyc", 64'(clr_valid), 64'd0);
    count_valid(300, cnt);
    check("t1_no_more", 64'(cnt), 64'd0);

    // ---- 2: sources 3 and 200, round-robin wrap ------------------------
    do_reset();
    clear_all();
    set_domain(0, 1'b1, 1'b1, 64'h2800_0000);
    set_src(3, 0, 1, 3);
    set_src(200, 0, 4, 'h7FF);
    msi_ready = 1'b1;
    release_reset();
    wait_msi(600, cycles);
    check("t2a_lat",  64'(cycles),   64'd3);
    check("t2a_addr", msi_addr,      64'h2800_1000);
    check("t2a_data", 64'(msi_data), 64'd3);
    @(negedge clk);
    check("t2a_clr_idx", 64'(clr_idx), 64'd3);
    pending[3] = 1'b0;
    wait_msi(600, cycles);
    check("t2b_lat",  64'(cycles),   64'd198);
    check("t2b_addr", msi_addr,      64'h2800_4000);
    check("t2b_data", 64'(msi_data), 64'h7FF);
    @(negedge clk);
    check("t2b_clr_idx", 64'(clr_idx), 64'd200);
    pending[200] = 1'b0;
    pending[3]   = 1'b1;
    wait_msi(600, cycles);
    check("t2c_lat",  64'(cycles),   64'd59);
    check("t2c_addr", msi_addr,      64'h2800_1000);
    @(negedge clk);
    check("t2c_clr_idx", 64'(clr_idx), 64'd3);
    pending[3] = 1'b0;

    // ---- 3: ready held low, request not retracted ----------------------
    do_reset();
    clear_all();
    set_domain(0, 1'b1, 1'b1, 64'h2800_0000);
    set_src(7, 0, 2, 'h155);
    release_reset();
    wait_msi(600, cycles);
    check("t3_lat", 64'(cycles), 64'd7);
    pending[7]   = 1'b0;
    domain_ie[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (msi_valid && msi_addr == 64'h2800_2000 && msi_data == 32'h155 && !clr_valid)
        cnt++;
    end
    check("t3_stable", 64'(cnt), 64'd10);
    msi_ready = 1'b1;
    @(negedge clk);
    check("t3_clr",     64'(clr_valid), 64'd1);
    check("t3_clr_idx", 64'(clr_idx),   64'd7);
    count_valid(300, cnt);
    check("t3_no_more", 64'(cnt), 64'd0);

    // ---- 4: non-qualifying sources skipped -----------------------------
    do_reset();
    clear_all();
    set_domain(0, 1'b1, 1'b1, 64'h2800_0000);
    set_domain(1, 1'b1, 1'b0, 64'h3000_0000);
    set_src(9, 0, 1, 0);          // EIID 0
    set_src(10, 1, 2, 'h10);      // direct-mode domain
    set_src(11, 0, 5, 'h11);      // hart out of range
    set_src(12, 0, 4, 'h12);      // valid marker after the skipped ones
    msi_ready = 1'b1;
    release_reset();
    wait_msi(600, cycles);
    check("t4_lat",  64'(cycles),   64'd12);
    check("t4_data", 64'(msi_data), 64'h12);
    check("t4_addr", msi_addr,      64'h2800_4000);
    @(negedge clk);
    check("t4_clr_idx", 64'(clr_idx), 64'd12);
    pending[12] = 1'b0;
    count_valid(600, cnt);
    check("t4_skipped", 64'(cnt), 64'd0);
    domain_mode[1] = 1'b1;        // domain 1 switches to MSI mode
    wait_msi(600, cycles);
    check("t4_d1_valid", 64'(msi_valid), 64'd1);
    check("t4_d1_addr",  msi_addr,       64'h3000_2000);
    check("t4_d1_data",  64'(msi_data),  64'h10);
    @(negedge clk);
    pending[10] = 1'b0;

    // ---- 5: reserved source 0 never signalled --------------------------
    do_reset();
    clear_all();
    set_domain(0, 1'b1, 1'b1, 64'h2800_0000);
    set_src(0, 0, 0, 1);
    msi_ready = 1'b1;
    release_reset();
    count_valid(600, cnt);
    check("t5_src0", 64'(cnt), 64'd0);

    // ---- 6: reset during ISSUE -----------------------------------------
    do_reset();
    clear_all();
    set_domain(0, 1'b1, 1'b1, 64'h2800_0000);
    set_src(20, 0, 1, 'h20);
    release_reset();
    wait_msi(600, cycles);
    check("t6_lat",   64'(cycles),    64'd20);
    check("t6_valid", 64'(msi_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_drop", 64'(msi_valid), 64'd0);
    check("t6_rst_idx",    64'(clr_idx),   64'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (clr_valid) cnt++;
    end
    check("t6_no_clr", 64'(cnt), 64'd0);
    release_reset();
    wait_msi(600, cycles);
    check("t6_re_lat",  64'(cycles),   64'd20);
    check("t6_re_addr", msi_addr,      64'h2800_1000);
    check("t6_re_data", 64'(msi_data), 64'h20);
    msi_ready = 1'b1;
    @(negedge clk);
    check("t6_clr_idx", 64'(clr_idx), 64'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
